// File: rtl/sync_fifo_param_pkg.sv
// rtl/sync_fifo_param_pkg.sv - shared defaults, operation encoding and width helper for sync_fifo_param
package sync_fifo_param_pkg;

    localparam int DEFAULT_DATA_WIDTH        = 16;
    localparam int DEFAULT_DEPTH             = 8;
    localparam int DEFAULT_ALMOST_FULL_LEVEL = 6;

    // Effective operation in one cycle, encoded as {do_push, do_pop}
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    // Bits needed to hold values 0..n-1 (n >= 2)
    function automatic int fifo_clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo_param_wrap_counter.sv
// rtl/sync_fifo_param_wrap_counter.sv - fifo_wrap_counter: 0..MAX-1 pointer counter with clear and wrap
module fifo_wrap_counter
    import sync_fifo_param_pkg::*;
#(
    parameter int MAX = 8
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       iClear,
    input  logic                       iEnable,
    output logic [fifo_clog2(MAX)-1:0] oValue
);

    localparam int                W    = fifo_clog2(MAX);
    localparam logic [W-1:0]      LAST = W'(MAX - 1);

    logic [W-1:0] r_value;

    // Clear wins over enable; wrap uses an explicit compare so MAX need not be a power of two
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_value <= '0;
        end else if (iClear) begin
            r_value <= '0;
        end else if (iEnable) begin
            if (r_value == LAST) begin
                r_value <= '0;
            end else begin
                r_value <= r_value + W'(1);
            end
        end
    end

    assign oValue = r_value;

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised FWFT single-clock FIFO; SYNC_FIFO_ERROR_FLAGS_EN adds sticky oOverflow/oUnderflow
module sync_fifo_param
    import sync_fifo_param_pkg::*;
#(
    parameter int DATA_WIDTH        = DEFAULT_DATA_WIDTH,
    parameter int DEPTH             = DEFAULT_DEPTH,
    parameter int ALMOST_FULL_LEVEL = DEFAULT_ALMOST_FULL_LEVEL
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic                           iFlush,
    input  logic                           iPush,
    input  logic [DATA_WIDTH-1:0]          iData,
    input  logic                           iPop,
    output logic [DATA_WIDTH-1:0]          oData,
    output logic                           oFull,
    output logic                           oEmpty,
    output logic                           oAlmostFull,
`ifdef SYNC_FIFO_ERROR_FLAGS_EN
    output logic                           oOverflow,
    output logic                           oUnderflow,
`endif
    output logic [fifo_clog2(DEPTH+1)-1:0] oCount
);

    localparam int AW = fifo_clog2(DEPTH);
    localparam int CW = fifo_clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]         r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_almost_full;

    logic [AW-1:0]         w_wr_ptr;
    logic [AW-1:0]         w_rd_ptr;
    logic                  w_do_push;
    logic                  w_do_pop;
    fifo_op_e              w_op;
    logic [CW-1:0]         w_count_next;

    // A full FIFO still accepts a push when the head is popped in the same cycle
    assign w_do_push = iPush & (~r_full | iPop);
    assign w_do_pop  = iPop & ~r_empty;

    fifo_wrap_counter #(.MAX(DEPTH)) u_wr_ptr (
        .Clock   (Clock),
        .Reset   (Reset),
        .iClear  (iFlush),
        .iEnable (w_do_push),
        .oValue  (w_wr_ptr)
    );

    fifo_wrap_counter #(.MAX(DEPTH)) u_rd_ptr (
        .Clock   (Clock),
        .Reset   (Reset),
        .iClear  (iFlush),
        .iEnable (w_do_pop),
        .oValue  (w_rd_ptr)
    );

    // Next occupancy: flush overrides, simultaneous push+pop leaves it unchanged
    always_comb begin
        w_op         = fifo_op_e'({w_do_push, w_do_pop});
        w_count_next = r_count;
        case (w_op)
            OP_PUSH: w_count_next = r_count + CW'(1);
            OP_POP:  w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
        if (iFlush) begin
            w_count_next = '0;
        end
    end

    // Storage is not reset; a flushed push is discarded
    always_ff @(posedge Clock) begin
        if (w_do_push && !iFlush) begin
            r_mem[w_wr_ptr] <= iData;
        end
    end

    // Count and flags register together from the next count
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_count       <= '0;
            r_full        <= 1'b0;
            r_empty       <= 1'b1;
            r_almost_full <= 1'b0;
        end else begin
            r_count       <= w_count_next;
            r_full        <= (w_count_next == CW'(DEPTH));
            r_empty       <= (w_count_next == '0);
            r_almost_full <= (w_count_next >= CW'(ALMOST_FULL_LEVEL));
        end
    end

`ifdef SYNC_FIFO_ERROR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky error flags: set on a dropped push or an ignored pop, cleared only by flush
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (iFlush) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (iPush && r_full && !iPop) begin
                r_overflow <= 1'b1;
            end
            if (iPop && r_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign oOverflow  = r_overflow;
    assign oUnderflow = r_underflow;
`endif

    assign oData       = r_mem[w_rd_ptr];
    assign oFull       = r_full;
    assign oEmpty      = r_empty;
    assign oAlmostFull = r_almost_full;
    assign oCount      = r_count;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - scoreboard bench for sync_fifo_param (DEPTH=8 and DEPTH=5 instances)
module tb_sync_fifo_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        flush8, push8, pop8;
    logic [15:0] din8, dout8;
    logic        full8, empty8, af8;
    logic [3:0]  cnt8;

    logic        flush5, push5, pop5;
    logic [15:0] din5, dout5;
    logic        full5, empty5, af5;
    logic [2:0]  cnt5;

`ifdef SYNC_FIFO_ERROR_FLAGS_EN
    logic ovf8, unf8, ovf5, unf5;
`endif

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp8[$];
    logic [15:0] exp5[$];

    sync_fifo_param #(.DATA_WIDTH(16), .DEPTH(8), .ALMOST_FULL_LEVEL(6)) dut8 (
        .Clock       (clk),
        .Reset       (rst_n),
        .iFlush      (flush8),
        .iPush       (push8),
        .iData       (din8),
        .iPop        (pop8),
        .oData       (dout8),
        .oFull       (full8),
        .oEmpty      (empty8),
        .oAlmostFull (af8),
`ifdef SYNC_FIFO_ERROR_FLAGS_EN
        .oOverflow   (ovf8),
        .oUnderflow  (unf8),
`endif
        .oCount      (cnt8)
    );

    sync_fifo_param #(.DATA_WIDTH(16), .DEPTH(5), .ALMOST_FULL_LEVEL(4)) dut5 (
        .Clock       (clk),
        .Reset       (rst_n),
        .iFlush      (flush5),
        .iPush       (push5),
        .iData       (din5),
        .iPop        (pop5),
        .oData       (dout5),
        .oFull       (full5),
        .oEmpty      (empty5),
        .oAlmostFull (af5),
`ifdef SYNC_FIFO_ERROR_FLAGS_EN
        .oOverflow   (ovf5),
        .oUnderflow  (unf5),
`endif
        .oCount      (cnt5)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitors: a pop that will be accepted at the next edge must present the scoreboard head
    always @(negedge clk) begin
        if (rst_n && pop8 && !flush8 && !empty8) begin
            if (exp8.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut8_pop_unexpected actual=0x%0h required=none", dout8);
            end else begin
                check("dut8_pop_data", {16'h0, dout8}, {16'h0, exp8.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && pop5 && !flush5 && !empty5) begin
            if (exp5.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut5_pop_unexpected actual=0x%0h required=none", dout5);
            end else begin
                check("dut5_pop_data", {16'h0, dout5}, {16'h0, exp5.pop_front()});
            end
        end
    end

    task automatic step8(input logic p, input logic [15:0] d, input logic q, input logic f);
        push8 = p; din8 = d; pop8 = q; flush8 = f;
        @(posedge clk); #1;
        push8 = 1'b0; pop8 = 1'b0; flush8 = 1'b0;
    endtask

    task automatic step5(input logic p, input logic [15:0] d, input logic q, input logic f);
        push5 = p; din5 = d; pop5 = q; flush5 = f;
        @(posedge clk); #1;
        push5 = 1'b0; pop5 = 1'b0; flush5 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        flush8 = 0; push8 = 0; pop8 = 0; din8 = '0;
        flush5 = 0; push5 = 0; pop5 = 0; din5 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_count8", cnt8, 0);
        check("reset_empty8", empty8, 1);
        check("reset_full8", full8, 0);
        check("reset_af8", af8, 0);
        check("reset_count5", cnt5, 0);
        check("reset_empty5", empty5, 1);
`ifdef SYNC_FIFO_ERROR_FLAGS_EN
        check("reset_ovf8", ovf8, 0);
        check("reset_unf8", unf8, 0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: fill with 0x0001..0x0008
        for (int i = 1; i <= 8; i++) begin
            step8(1, 16'(i), 0, 0);
            exp8.push_back(16'(i));
            check("t1_count", cnt8, i);
            check("t1_empty", empty8, 0);
            check("t1_af", af8, (i >= 6) ? 1 : 0);
            check("t1_full", full8, (i == 8) ? 1 : 0);
        end
        check("t1_head", dout8, 16'h0001);

        // 2: drain, monitor checks order 0x0001..0x0008
        for (int i = 0; i < 8; i++) step8(0, 0, 1, 0);
        check("t2_empty", empty8, 1);
        check("t2_count", cnt8, 0);
        check("t2_af", af8, 0);

        // 3: full + push 0x00AA + pop
        for (int i = 0; i < 8; i++) begin
            step8(1, 16'h0011 + 16'(i), 0, 0);
            exp8.push_back(16'h0011 + 16'(i));
        end
        step8(1, 16'h00AA, 1, 0);
        exp8.push_back(16'h00AA);
        check("t3_count", cnt8, 8);
        check("t3_full", full8, 1);
        check("t3_head", dout8, 16'h0012);
        for (int i = 0; i < 7; i++) step8(0, 0, 1, 0);
        check("t3_eighth_head", dout8, 16'h00AA);
        step8(0, 0, 1, 0);
        check("t3_count_end", cnt8, 0);

        // 4: empty + push 0x0055 + pop
        step8(1, 16'h0055, 1, 0);
        exp8.push_back(16'h0055);
        check("t4_count", cnt8, 1);
        check("t4_empty", empty8, 0);
        check("t4_head", dout8, 16'h0055);
        step8(0, 0, 1, 0);
        check("t4_empty_end", empty8, 1);

        // flush beats push and pop in the same cycle
        for (int i = 0; i < 3; i++) begin
            step8(1, 16'h0031 + 16'(i), 0, 0);
            exp8.push_back(16'h0031 + 16'(i));
        end
        step8(1, 16'h0077, 1, 1);
        exp8.delete();
        check("flush_count", cnt8, 0);
        check("flush_empty", empty8, 1);
        step8(1, 16'h0099, 0, 0);
        exp8.push_back(16'h0099);
        check("flush_after_head", dout8, 16'h0099);
        check("flush_after_count", cnt8, 1);
        step8(0, 0, 1, 0);

        // 5: DEPTH=5, 12 push/pop pairs wrap pointers 4->0 twice
        for (int i = 0; i < 12; i++) begin
            step5(1, 16'h0100 + 16'(i), 0, 0);
            exp5.push_back(16'h0100 + 16'(i));
            check("t5_count_push", cnt5, 1);
            step5(0, 0, 1, 0);
            check("t5_empty_pop", empty5, 1);
        end
        for (int i = 0; i < 5; i++) begin
            step5(1, 16'h0200 + 16'(i), 0, 0);
            exp5.push_back(16'h0200 + 16'(i));
            check("t5_af", af5, (i >= 3) ? 1 : 0);
        end
        check("t5_full", full5, 1);
        check("t5_count_full", cnt5, 5);
        step5(1, 16'h01AA, 1, 0);
        exp5.push_back(16'h01AA);
        check("t5_count_both", cnt5, 5);
        for (int i = 0; i < 5; i++) step5(0, 0, 1, 0);
        check("t5_empty_end", empty5, 1);

        // 6: overflow then underflow
        for (int i = 0; i < 8; i++) begin
            step8(1, 16'h0061 + 16'(i), 0, 0);
            exp8.push_back(16'h0061 + 16'(i));
        end
        step8(1, 16'h00EE, 0, 0);
        check("t6_count_drop", cnt8, 8);
        check("t6_head_drop", dout8, 16'h0061);
`ifdef SYNC_FIFO_ERROR_FLAGS_EN
        check("t6_ovf_set", ovf8, 1);
        check("t6_unf_clear", unf8, 0);
`endif
        for (int i = 0; i < 8; i++) step8(0, 0, 1, 0);
        step8(0, 0, 1, 0);
        check("t6_count_empty_pop", cnt8, 0);
        check("t6_empty_empty_pop", empty8, 1);
`ifdef SYNC_FIFO_ERROR_FLAGS_EN
        check("t6_unf_set", unf8, 1);
        check("t6_ovf_sticky", ovf8, 1);
        step8(0, 0, 0, 1);
        check("t6_ovf_flushed", ovf8, 0);
        check("t6_unf_flushed", unf8, 0);
`endif

        // reset low mid-burst
        step8(1, 16'h0041, 0, 0);
        step8(1, 16'h0042, 0, 0);
        push8 = 1'b1; din8 = 16'h0043;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_count", cnt8, 0);
        check("rst_mid_empty", empty8, 1);
        check("rst_mid_full", full8, 0);
        push8 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_after_count", cnt8, 0);
        step8(1, 16'h0081, 0, 0);
        exp8.push_back(16'h0081);
        check("rst_after_head", dout8, 16'h0081);
        step8(0, 0, 1, 0);

        check("sb8_drained", exp8.size(), 0);
        check("sb5_drained", exp5.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
